// File: rtl/nn_pkg.sv
// Shared types, saturation limits and helpers for the neuron MAC datapath.
package nn_pkg;

   typedef enum logic [2:0] {
      IDLE,
      POP,
      WAIT,
      MAC,
      FINISH,
      OUT
   } nn_state_e;

   typedef logic signed [7:0] act_t;
   typedef logic signed [7:0] wgt_t;

   localparam logic signed [7:0] INT8_MAX = 8'h7F;
   localparam logic signed [7:0] INT8_MIN = 8'h80;

   // Lane 0 sits in the least significant byte of a packed FIFO word.
   function automatic act_t lane_extract(input logic [31:0] word, input logic [1:0] lane);
      return act_t'(word[{lane, 3'b000} +: 8]);
   endfunction

endpackage

// File: rtl/nn_sat_requant.sv
// Bias add, arithmetic shift and int8 saturation of a neuron accumulator.
// Build option NN_NEURON_RELU_EN clamps negative results to zero after saturation.
module nn_sat_requant
   import nn_pkg::*;
#(
   parameter int ACC_W = 24,
   parameter int SHIFT = 6
) (
   input  logic [ACC_W-1:0] acc_i,
   input  logic [ACC_W-1:0] bias_i,
   output logic [7:0]       res_o
);

   logic signed [ACC_W:0] sum;
   logic signed [ACC_W:0] shifted;
   act_t                  sat;

   // One guard bit keeps acc + bias exact for any bias value.
   always_comb begin
      sum     = $signed({acc_i[ACC_W-1], acc_i}) + $signed({bias_i[ACC_W-1], bias_i});
      shifted = sum >>> SHIFT;
      if (shifted > (ACC_W+1)'(INT8_MAX)) begin
         sat = INT8_MAX;
      end else if (shifted < (ACC_W+1)'(INT8_MIN)) begin
         sat = INT8_MIN;
      end else begin
         sat = act_t'(shifted[7:0]);
      end
`ifdef NN_NEURON_RELU_EN
      if (sat[7]) begin
         sat = '0;
      end
`else
      sat = sat;
`endif
      res_o = sat;
   end

endmodule

// File: rtl/nn_neuron_mac.sv
// Neuron evaluator: pops packed int8 activations, MACs against a weight bank, requantizes.
// state  | meaning
// IDLE   | waiting for start; weight/bias writes accepted
// POP    | pop strobe once the input FIFO has a word
// WAIT   | capture popped FIFO word, lane = 0
// MAC    | accumulate one lane per cycle
// FINISH | bias, shift, saturate into the result register
// OUT    | hold result valid until the consumer takes it
module nn_neuron_mac
   import nn_pkg::*;
#(
   parameter  int N_INPUTS = 16,
   parameter  int ACC_W    = 24,
   parameter  int SHIFT    = 6,
   localparam int IDX_W    = $clog2(N_INPUTS)
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n_i,
   input  logic              start_i,
   output logic              busy_o,
   input  logic              fifo_empty_i,
   input  logic [31:0]       fifo_data_i,
   output logic              fifo_rd_o,
   input  logic              wgt_we_i,
   input  logic [IDX_W-1:0]  wgt_addr_i,
   input  logic [7:0]        wgt_data_i,
   input  logic              bias_we_i,
   input  logic [ACC_W-1:0]  bias_i,
   output logic [7:0]        result_o,
   output logic              result_valid_o,
   input  logic              result_ready_i
);

   localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(N_INPUTS/4 - 1);

   nn_state_e        state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] bias_q;
   logic [IDX_W-1:0] word_idx_q, word_idx_d;
   logic [1:0]       lane_q, lane_d;
   logic [31:0]      word_q, word_d;
   logic [7:0]       result_q, result_d;
   logic             valid_q, valid_d;
   wgt_t             wgt_q [N_INPUTS];

   logic [IDX_W-1:0] wgt_idx;
   act_t             act;
   wgt_t             wgt;
   logic [15:0]      prod;
   logic [7:0]       requant;
   logic             cfg_open;

   assign cfg_open = (state_q == IDLE);
   assign wgt_idx  = IDX_W'({word_idx_q, lane_q});
   assign act      = lane_extract(word_q, lane_q);
   assign wgt      = wgt_q[wgt_idx];
   assign prod     = {{8{act[7]}}, act} * {{8{wgt[7]}}, wgt};

   nn_sat_requant #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT)
   ) u_requant (
      .acc_i  (acc_q),
      .bias_i (bias_q),
      .res_o  (requant)
   );

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      word_idx_d = word_idx_q;
      lane_d     = lane_q;
      word_d     = word_q;
      result_d   = result_q;
      valid_d    = valid_q;
      fifo_rd_o  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               acc_d      = '0;
               word_idx_d = '0;
               state_d    = POP;
            end
         end
         POP: begin
            if (!fifo_empty_i) begin
               fifo_rd_o = 1'b1;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            word_d  = fifo_data_i;
            lane_d  = '0;
            state_d = MAC;
         end
         MAC: begin
            acc_d  = acc_q + {{(ACC_W-16){prod[15]}}, prod};
            lane_d = lane_q + 2'd1;
            if (lane_q == 2'd3) begin
               if (word_idx_q == LAST_WORD) begin
                  state_d = FINISH;
               end else begin
                  word_idx_d = word_idx_q + IDX_W'(1);
                  state_d    = POP;
               end
            end
         end
         FINISH: begin
            result_d = requant;
            valid_d  = 1'b1;
            state_d  = OUT;
         end
         OUT: begin
            if (result_ready_i) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         word_idx_q <= '0;
         lane_q     <= '0;
         word_q     <= '0;
         result_q   <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         word_idx_q <= word_idx_d;
         lane_q     <= lane_d;
         word_q     <= word_d;
         result_q   <= result_d;
         valid_q    <= valid_d;
      end
   end

   // Configuration is frozen for the whole evaluation.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         for (int i = 0; i < N_INPUTS; i++) begin
            wgt_q[i] <= '0;
         end
         bias_q <= '0;
      end else if (cfg_open) begin
         if (wgt_we_i) begin
            wgt_q[wgt_addr_i] <= wgt_data_i;
         end
         if (bias_we_i) begin
            bias_q <= bias_i;
         end
      end
   end

   assign busy_o         = (state_q != IDLE);
   assign result_o       = result_q;
   assign result_valid_o = valid_q;

endmodule

// File: doc/nn_neuron_mac.md
Name: nn_neuron_mac

Overview:
- Downstream consumer of the Wishbone input FIFO in the wishbone_nn design.
- Pops 32-bit words, each packing four signed int8 activations, and multiply-accumulates them against a local int8 weight bank.
- Adds a bias, requantizes to int8, and presents one result per evaluation on a valid/ready output toward the readback path.
- Weights and bias are written by the Wishbone programmable-address decode.

Parameters:
- N_INPUTS, 16, activations per neuron; must be a multiple of 4; N_INPUTS/4 FIFO words per evaluation
- ACC_W, 24, signed accumulator width
- SHIFT, 6, arithmetic right shift applied before int8 saturation

Ports:
- wb_clk_i  in  1  clock
- wb_rst_n_i  in  1  asynchronous active-low reset
- start_i  in  1  pulse; begin one evaluation
- busy_o  out  1  high from accepted start until result handshake
- fifo_empty_i  in  1  input FIFO empty
- fifo_data_i  in  32  FIFO read data, valid the cycle after fifo_rd_o
- fifo_rd_o  out  1  FIFO pop strobe
- wgt_we_i  in  1  weight write strobe
- wgt_addr_i  in  $clog2(N_INPUTS)  weight index
- wgt_data_i  in  8  signed weight
- bias_we_i  in  1  bias write strobe
- bias_i  in  ACC_W  signed bias
- result_o  out  8  signed requantized result
- result_valid_o  out  1  result available
- result_ready_i  in  1  consumer accepts result

Behaviour:
- Reset (async, wb_rst_n_i=0) sets state IDLE, fifo_rd_o=0, busy_o=0, result_valid_o=0, result_o=0, acc=0, word and lane counters=0, all weights=0, bias=0.
- FSM states:
  - IDLE: start_i=1 -> clear acc, word_idx=0; busy_o=1; go POP.
  - POP: if !fifo_empty_i, assert fifo_rd_o for exactly one cycle and go WAIT; otherwise hold in POP with fifo_rd_o=0.
  - WAIT: capture fifo_data_i into the word register, lane=0; go MAC.
  - MAC: one lane per cycle. acc += sext(act[lane]) * sext(w[word_idx*4+lane]). Lane 0 is bits [7:0], lane 3 is bits [31:24]. After lane 3: if word_idx==N_INPUTS/4-1 go FINISH, else word_idx++ and go POP.
  - FINISH: t = (acc + bias) >>> SHIFT (arithmetic); result_o = sat(t) clamped to [-128,127]; result_valid_o=1; go OUT.
  - OUT: hold result_o and result_valid_o stable until result_ready_i=1; in that cycle drop valid and busy_o and go IDLE.
- Products are 16-bit signed and sign-extended to ACC_W. acc wraps modulo 2^ACC_W; no overflow flag. The default width cannot overflow for N_INPUTS ≤ 16.
- Latency with FIFO never empty: 1 + (N_INPUTS/4)*6 + 1 cycles from start to result_valid_o (26 with defaults).
- start_i while busy_o=1 is ignored.
- Weight and bias writes are accepted only while busy_o=0 and ignored while busy. Both strobes may fire in the same cycle.
- result_ready_i outside OUT has no effect.
- An empty FIFO mid-evaluation stalls in POP indefinitely and acc is preserved.
- Reset mid-operation aborts the evaluation. Any FIFO word already popped is lost; the upstream must be flushed by the same reset.

Optional Feature:
- Macro: NN_NEURON_RELU_EN.
- Defined: ReLU is applied after saturation, so negative results become 0 and result_o ∈ [0,127].
- Undefined: signed saturated result passes unchanged.

Decomposition:
- Shared package nn_pkg holds:
  - FSM state enum (IDLE, POP, WAIT, MAC, FINISH, OUT)
  - int8 activation and weight typedefs
  - the INT8_MAX/INT8_MIN saturation constants
  - the lane-extract function
- One natural sub-module: nn_sat_requant, a combinational block for bias add, shift, saturate and optional ReLU. It is reused later by the output stage.

Test Plan:
- Weights all 1, bias 0, four words 0x01010101 -> acc=16, result_o=0 (16>>>6), valid after 26 cycles.
- Weights all 127, bias 0, activations all 0x7F (4 words) -> acc=258064, >>>6 = 4032, result_o=127 (saturate high).
- Weights all -128, activations all 0x7F -> result_o=-128. With NN_NEURON_RELU_EN: result_o=0.
- FIFO empty for 10 cycles after word 1 -> fifo_rd_o stays low, busy_o high, final result identical to the no-stall run.
- Hold result_ready_i low 5 cycles in OUT -> result_o and result_valid_o stable. Weight write during busy -> weight unchanged. start_i during busy -> ignored.
- Assert wb_rst_n_i low during MAC of word 2 -> all outputs 0 next edge. Fresh start after reset -> correct result with reset weights (result 0).
